// File: rtl/ula_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ula_seq_ctrl -- sequencing controller for an 8-bit ALU (ULA).
//
// Accepts one operation request in IDLE, registers the operands and the
// opcode, drives a one-hot operation select to an external combinational
// ALU while in EXEC, and captures the ALU result on the last EXEC cycle.
// Multiply and divide (opcodes 010/011) stay in EXEC for MD_WAIT extra
// cycles so a slower datapath has time to settle.
//
// Parameters:
//   MD_WAIT   extra EXEC cycles for multi/div (0..15)
//
// Optional feature (macro ULA_DIV0_CHK_EN):
//   When defined, a divide accepted with b_in == 0 skips the wait, takes a
//   single EXEC cycle and reports result 8'hFF with err_div0 = 1. When not
//   defined, divide behaves like any other multi-cycle op and err_div0 is 0.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only in IDLE
//   opcode    in   3-bit operation code (000 soma ... 111 not)
//   a_in      in   operand A
//   b_in      in   operand B
//   alu_res   in   combinational ALU result
//   a_out     out  registered operand A to the ALU
//   b_out     out  registered operand B to the ALU
//   sel_op    out  one-hot operation select (8'h00 in IDLE)
//   busy      out  high while in EXEC
//   done      out  one-cycle completion pulse
//   result    out  captured result, held until the next capture
//   zero      out  result == 0, registered with result
//   err_div0  out  divide-by-zero flag, registered with result
//
// Handshake: start is a level request. It is accepted on any rising edge
// where the controller is IDLE (including the cycle done is high); while
// busy is high start is ignored and nothing is queued.
// ----------------------------------------------------------------------------
module ula_seq_ctrl #(
    parameter int unsigned MD_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic [7:0] alu_res,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [7:0] sel_op,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       zero,
    output logic       err_div0
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    localparam logic [3:0] MD_WAIT_C = 4'(MD_WAIT);

    state_e     state_q,  state_d;
    logic [3:0] wcnt_q,   wcnt_d;
    logic [7:0] a_q,      a_d;
    logic [7:0] b_q,      b_d;
    logic [2:0] op_q,     op_d;
    logic [7:0] result_q, result_d;
    logic       zero_q,   zero_d;
    logic       done_q,   done_d;
`ifdef ULA_DIV0_CHK_EN
    logic       div0_q,   div0_d;
    logic       err_q,    err_d;
`endif

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifdef ULA_DIV0_CHK_EN
        div0_d   = div0_q;
        err_d    = err_q;
`endif

        if (state_q == IDLE) begin
            if (start) begin
                a_d     = a_in;
                b_d     = b_in;
                op_d    = opcode;
                wcnt_d  = (opcode == 3'b010 || opcode == 3'b011) ? MD_WAIT_C : 4'd0;
`ifdef ULA_DIV0_CHK_EN
                // Divide by zero is resolved locally, so no settle time needed.
                div0_d  = (opcode == 3'b011) && (b_in == 8'h00);
                if (div0_d) begin
                    wcnt_d = 4'd0;
                end
`endif
                state_d = EXEC;
            end
        end else begin
            if (wcnt_q != 4'd0) begin
                wcnt_d = wcnt_q - 4'd1;
            end else begin
                result_d = alu_res;
                zero_d   = (alu_res == 8'h00);
`ifdef ULA_DIV0_CHK_EN
                err_d    = 1'b0;
                if (div0_q) begin
                    result_d = 8'hFF;
                    zero_d   = 1'b0;
                    err_d    = 1'b1;
                end
`endif
                done_d   = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wcnt_q   <= 4'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 3'b000;
            result_q <= 8'h00;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef ULA_DIV0_CHK_EN
            div0_q   <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifdef ULA_DIV0_CHK_EN
            div0_q   <= div0_d;
            err_q    <= err_d;
`endif
        end
    end

    // The select is decoded from registered state only, so it is glitch-free
    // relative to input changes and drops to zero as soon as reset asserts.
    assign sel_op = (state_q == EXEC) ? (8'h01 << op_q) : 8'h00;
    assign busy   = (state_q == EXEC);
    assign done   = done_q;
    assign a_out  = a_q;
    assign b_out  = b_q;
    assign result = result_q;
    assign zero   = zero_q;
`ifdef ULA_DIV0_CHK_EN
    assign err_div0 = err_q;
`else
    assign err_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ula_seq_ctrl -- directed self-checking bench for ula_seq_ctrl.
//
// A small behavioural ALU drives alu_res from a_out/b_out/sel_op. Inputs are
// driven and outputs sampled 1 time unit after each rising edge. Expected
// values are hand-computed constants for MD_WAIT = 3.
// ----------------------------------------------------------------------------
module tb_ula_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] opcode;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] alu_res;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [7:0] sel_op;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       err_div0;

    int checks = 0;
    int errors = 0;

    ula_seq_ctrl #(.MD_WAIT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opcode   (opcode),
        .a_in     (a_in),
        .b_in     (b_in),
        .alu_res  (alu_res),
        .a_out    (a_out),
        .b_out    (b_out),
        .sel_op   (sel_op),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .err_div0 (err_div0)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; divide by zero returns a recognisable 8'hEE.
    always_comb begin
        alu_res = 8'h00;
        case (sel_op)
            8'h01: alu_res = a_out + b_out;
            8'h02: alu_res = a_out - b_out;
            8'h04: alu_res = a_out * b_out;
            8'h08: alu_res = (b_out == 8'h00) ? 8'hEE : a_out / b_out;
            8'h10: alu_res = a_out & b_out;
            8'h20: alu_res = a_out | b_out;
            8'h40: alu_res = a_out ^ b_out;
            8'h80: alu_res = ~a_out;
            default: alu_res = 8'h00;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        start  = 1'b1;
        opcode = op;
        a_in   = a;
        b_in   = b;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 3'b000;
        a_in   = 8'h00;
        b_in   = 8'h00;
        #12;

        // Reset values
        chk("rst_a_out",  a_out,  8'h00);
        chk("rst_b_out",  b_out,  8'h00);
        chk("rst_sel_op", sel_op, 8'h00);
        chk("rst_result", result, 8'h00);
        chk("rst_zero",   {7'd0, zero},     8'h01);
        chk("rst_err",    {7'd0, err_div0}, 8'h00);
        chk("rst_busy",   {7'd0, busy},     8'h00);
        chk("rst_done",   {7'd0, done},     8'h00);

        // Soma, issued for the first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b000, 8'h12, 8'h34);
        tick();
        chk("soma_busy",  {7'd0, busy}, 8'h01);
        chk("soma_sel",   sel_op, 8'h01);
        chk("soma_a_out", a_out,  8'h12);
        chk("soma_b_out", b_out,  8'h34);
        chk("soma_done0", {7'd0, done}, 8'h00);
        start = 1'b0;
        tick();
        chk("soma_done",   {7'd0, done}, 8'h01);
        chk("soma_busy0",  {7'd0, busy}, 8'h00);
        chk("soma_result", result, 8'h46);
        chk("soma_zero",   {7'd0, zero}, 8'h00);
        chk("soma_sel0",   sel_op, 8'h00);
        tick();
        chk("soma_pulse",  {7'd0, done}, 8'h00);
        chk("soma_hold",   result, 8'h46);

        // Idle with start low: outputs hold
        tick();
        chk("idle_busy", {7'd0, busy}, 8'h00);
        chk("idle_a",    a_out, 8'h12);

        // Multi with start held and inputs changing during EXEC
        issue(3'b010, 8'h05, 8'h07);
        tick();
        chk("mul_busy1", {7'd0, busy}, 8'h01);
        chk("mul_sel1",  sel_op, 8'h04);
        issue(3'b110, 8'hAA, 8'h55);
        tick();
        chk("mul_busy2", {7'd0, busy}, 8'h01);
        chk("mul_sel2",  sel_op, 8'h04);
        chk("mul_a2",    a_out, 8'h05);
        chk("mul_b2",    b_out, 8'h07);
        issue(3'b111, 8'h01, 8'h02);
        tick();
        chk("mul_busy3", {7'd0, busy}, 8'h01);
        tick();
        chk("mul_busy4", {7'd0, busy}, 8'h01);
        chk("mul_sel4",  sel_op, 8'h04);
        chk("mul_done4", {7'd0, done}, 8'h00);
        tick();
        chk("mul_done",   {7'd0, done}, 8'h01);
        chk("mul_busy5",  {7'd0, busy}, 8'h00);
        chk("mul_result", result, 8'h23);
        chk("mul_zero",   {7'd0, zero}, 8'h00);

        // Back-to-back: xor issued in the done cycle
        issue(3'b110, 8'hF0, 8'hFF);
        tick();
        chk("b2b_busy", {7'd0, busy}, 8'h01);
        chk("b2b_sel",  sel_op, 8'h40);
        chk("b2b_done0", {7'd0, done}, 8'h00);
        start = 1'b0;
        tick();
        chk("b2b_done",   {7'd0, done}, 8'h01);
        chk("b2b_result", result, 8'h0F);

        // Zero flag from subtraction
        issue(3'b001, 8'h55, 8'h55);
        tick();
        chk("sub_sel", sel_op, 8'h02);
        start = 1'b0;
        tick();
        chk("sub_done",   {7'd0, done}, 8'h01);
        chk("sub_result", result, 8'h00);
        chk("sub_zero",   {7'd0, zero}, 8'h01);

        // Divide by zero
        issue(3'b011, 8'h20, 8'h00);
        tick();
        chk("div_sel", sel_op, 8'h08);
        start = 1'b0;
`ifdef ULA_DIV0_CHK_EN
        tick();
        chk("div_done",   {7'd0, done}, 8'h01);
        chk("div_result", result, 8'hFF);
        chk("div_zero",   {7'd0, zero}, 8'h00);
        chk("div_err",    {7'd0, err_div0}, 8'h01);
`else
        tick();
        chk("div_busy2", {7'd0, busy}, 8'h01);
        tick();
        chk("div_busy3", {7'd0, busy}, 8'h01);
        tick();
        chk("div_busy4", {7'd0, busy}, 8'h01);
        chk("div_done0", {7'd0, done}, 8'h00);
        tick();
        chk("div_done",   {7'd0, done}, 8'h01);
        chk("div_result", result, 8'hEE);
        chk("div_zero",   {7'd0, zero}, 8'h00);
        chk("div_err",    {7'd0, err_div0}, 8'h00);
`endif
        tick();

        // Reset mid-EXEC of a multi
        issue(3'b010, 8'h03, 8'h04);
        tick();
        start = 1'b0;
        tick();
        chk("rme_busy_pre", {7'd0, busy}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rme_busy",   {7'd0, busy}, 8'h00);
        chk("rme_sel",    sel_op, 8'h00);
        chk("rme_a_out",  a_out,  8'h00);
        chk("rme_b_out",  b_out,  8'h00);
        chk("rme_result", result, 8'h00);
        chk("rme_zero",   {7'd0, zero},     8'h01);
        chk("rme_err",    {7'd0, err_div0}, 8'h00);
        chk("rme_done",   {7'd0, done},     8'h00);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rme_no_done", {7'd0, done}, 8'h00);
        end
        chk("rme_result_hold", result, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_seq_ctrl.md
ULA_SEQ_CTRL -- requirements
Module: ula_seq_ctrl

Interface
REQ-001 SHALL have parameter MD_WAIT, default 3, extra EXEC cycles for multi/div (range 0..15).
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  operation request, sampled only in IDLE
- opcode  in  3  000 soma, 001 sub, 010 multi, 011 div, 100 and, 101 or, 110 xor, 111 not
- a_in  in  8  operand A
- b_in  in  8  operand B
- alu_res  in  8  combinational ALU result (output of the 8-to-1 operation mux)
- a_out  out  8  registered operand A to ALU
- b_out  out  8  registered operand B to ALU
- sel_op  out  8  one-hot select; bit n = opcode n (bit0 sel_soma ... bit7 sel_not)
- busy  out  1  high while state is EXEC
- done  out  1  one-cycle completion pulse
- result  out  8  captured result, held until next capture
- zero  out  1  result == 0, registered with result
- err_div0  out  1  division by zero flag, registered with result

Function
REQ-003 SHALL implement two states, IDLE and EXEC, plus a 4-bit wait counter wcnt.
REQ-004 In IDLE with start=1 at an edge: SHALL latch a_in/b_in into a_out/b_out, latch opcode, load wcnt = MD_WAIT for opcode 010/011 else 0, enter EXEC.
REQ-005 In IDLE with start=0: SHALL remain in IDLE, all registered outputs hold.
REQ-006 sel_op SHALL be 8'h00 in IDLE and exactly one-hot (decoded latched opcode) in EXEC.
REQ-007 In EXEC with wcnt != 0: SHALL decrement wcnt, stay in EXEC.
REQ-008 In EXEC with wcnt == 0: SHALL capture result <= alu_res, zero <= (alu_res == 0), err_div0 <= 0, pulse done=1 for the following cycle, return to IDLE.
REQ-009 Latency: done SHALL assert 1 cycle after the accepting edge for single-cycle ops, 1+MD_WAIT cycles for multi/div.
REQ-010 start while in EXEC SHALL be ignored (no queueing); a_in/b_in/opcode changes in EXEC SHALL not affect a_out/b_out/sel_op.
REQ-011 start=1 in the cycle done=1 (state IDLE) SHALL be accepted; back-to-back ops SHALL sustain one op per 2 cycles (single-cycle ops).
REQ-012 busy SHALL equal (state == EXEC); busy and done SHALL never be high simultaneously.
REQ-013 wcnt SHALL never underflow; MD_WAIT=0 SHALL make multi/div single-cycle.

Reset
REQ-014 rst_n low SHALL immediately (asynchronously) force state IDLE, wcnt 0, a_out/b_out 8'h00, sel_op 8'h00, result 8'h00, zero 1, err_div0 0, busy 0, done 0.
REQ-015 Reset asserted mid-EXEC SHALL abort the operation with no done pulse and no result update.
REQ-016 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-017 With macro ULA_DIV0_CHK_EN defined: opcode 011 with b_in == 0 at accept SHALL skip the wait, take one EXEC cycle, capture result 8'hFF, zero 0, err_div0 1, pulse done.
REQ-018 Without ULA_DIV0_CHK_EN: division SHALL follow REQ-004..REQ-008 unchanged, err_div0 SHALL be constant 0.

Verification
REQ-019 Reset: rst_n low mid-EXEC of multi -> outputs at REQ-014 values immediately, no done pulse.
REQ-020 Soma: start, opcode 000, a=8'h12, b=8'h34, ALU model returns 8'h46 -> sel_op 8'h01 for 1 cycle, done next cycle, result 8'h46, zero 0.
REQ-021 Multi, MD_WAIT=3: opcode 010, a=5, b=7 -> busy 4 cycles, sel_op 8'h04, done on 5th cycle after accept, result 8'h23.
REQ-022 Ignore/back-to-back: start held with opcode changing during EXEC -> latched op unchanged; start in done cycle (xor 8'hF0, 8'hFF) -> accepted, result 8'h0F.
REQ-023 Zero flag: opcode 001, a=b=8'h55 -> result 8'h00, zero 1.
REQ-024 Div by zero, opcode 011, a=8'h20, b=0: with ULA_DIV0_CHK_EN -> done after 1 cycle, result 8'hFF, err_div0 1; without -> done after 1+MD_WAIT cycles, result = alu_res, err_div0 0.
